hex_keypad_scanner: RTL

- Scans a 4x4 matrix keypad and produces debounced hex key codes. It is the input-side counterpart of the multiplexed seg7x16 display driver: it drives active-low row selects and reads active-low columns.
- Accepted digits shift into a 32-bit value register. That register feeds the display driver's i_data directly, so entered digits appear on the rightmost digit and scroll left.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scan_tick.sv | 20 ++
 rtl/hex_keypad_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } kp_state_t;

  localparam logic [3:0] ROW_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] NO_KEY = 4'hF;

  // Hex code of a key: row*4 + col.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Lowest-numbered active-low column wins when several are pressed.
  function automatic logic [1:0] first_low_col(input logic [3:0] col);
    logic [1:0] idx;
    casez (col)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider producing a one-clk tick every 2^SCAN_DIV_W cycles.
module keypad_scan_tick #(
  parameter int unsigned SCAN_DIV_W = 15
) (
  input  logic clk,
  input  logic rstn,
  output logic o_tick
);

  logic [SCAN_DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div <= '0;
    else       div <= div + SCAN_DIV_W'(1);
  end

  // High during the cycle whose closing edge wraps the divider to zero.
  assign o_tick = &div;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a 32-bit digit shift register.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W     = 15,
  parameter int unsigned DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 32,
  parameter int unsigned REPEAT_RATE    = 8
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  i_col,
  input  logic        i_clr,
  output logic [3:0]  o_row,
  output logic        o_key_valid,
  output logic [3:0]  o_key_code,
  output logic        o_key_held,
  output logic [31:0] o_value
);

  localparam int unsigned CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [3:0]    col_m, col_s;
  logic          tick;
  kp_state_t     state;
  logic [1:0]    row_idx, row_nxt, lat_col;
  logic [CW-1:0] db_cnt, rel_cnt;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
`endif

  keypad_scan_tick #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .o_tick(tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_m <= NO_KEY;
      col_s <= NO_KEY;
    end else begin
      col_m <= i_col;
      col_s <= col_m;
    end
  end

  assign row_nxt = row_idx + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= SCAN;
      row_idx     <= '0;
      lat_col     <= '0;
      db_cnt      <= '0;
      rel_cnt     <= '0;
      o_row       <= ROW_SEL[0];
      o_key_valid <= 1'b0;
      o_key_code  <= '0;
      o_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt     <= '0;
      rep_phase   <= 1'b0;
`endif
    end else begin
      o_key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (col_s != NO_KEY) begin
              lat_col <= first_low_col(col_s);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_idx <= row_nxt;
              o_row   <= ROW_SEL[row_nxt];
            end
          end
          DEBOUNCE: begin
            if (!col_s[lat_col]) begin
              db_cnt <= db_cnt + CW'(1);
              // The detecting tick counts as the first stable one.
              if (db_cnt == CW'(DEBOUNCE_TICKS - 2)) begin
                state       <= PRESSED;
                o_key_valid <= 1'b1;
                o_key_code  <= key_code(row_idx, lat_col);
                o_key_held  <= 1'b1;
                rel_cnt     <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt     <= '0;
                rep_phase   <= 1'b0;
`endif
              end
            end else begin
              state   <= SCAN;
              row_idx <= row_nxt;
              o_row   <= ROW_SEL[row_nxt];
            end
          end
          PRESSED: begin
            if (col_s[lat_col]) begin
              if (rel_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                o_key_held <= 1'b0;
                state      <= SCAN;
                row_idx    <= row_nxt;
                o_row      <= ROW_SEL[row_nxt];
              end else begin
                rel_cnt <= rel_cnt + CW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt == (rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
              rep_cnt   <= '0;
              rep_phase <= 1'b1;
              if (!col_s[lat_col]) o_key_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
`endif
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  // Shift follows the cycle o_key_valid is high; a clear in that cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            o_value <= '0;
    else if (i_clr)       o_value <= '0;
    else if (o_key_valid) o_value <= {o_value[27:0], o_key_code};
  end

endmodule
